// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order memory requests from a fetch PC, buffers the
// returned words in a small FIFO for decode, and discards responses orphaned by a redirect.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCsrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic             IReqValid,
  output logic [WIDTH-1:0] IReqAddr,
  input  logic             IReqReady,
  input  logic             IRespValid,
  input  logic [WIDTH-1:0] IRespData,
  output logic             ValidF,
  input  logic             ReadyD,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCPlus4F
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  // One extra bit so counters can hold the value DEPTH itself.
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [WIDTH-1:0] word_t;

  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);
  localparam word_t         ResetPc  = {RESET_PC[WIDTH-1:2], 2'b00};

  word_t            pc_q, pc_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  ptr_t             fill_ptr_q, fill_ptr_d;
  cnt_t             count_q, count_d;
  cnt_t             pend_q, pend_d;
  cnt_t             drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  word_t            pc_mem_q    [DEPTH];
  word_t            pc_mem_d    [DEPTH];
  word_t            instr_mem_q [DEPTH];
  word_t            instr_mem_d [DEPTH];

  logic          req_valid;
  logic          valid_f;
  logic          req_fire;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;
  logic [CntW:0] occupancy;
  cnt_t          outstanding;
  word_t         head_pc;

  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^PCTargetE[1:0];

  // Buffer slots plus responses still owed to a cancelled stream bound the requests in flight.
  assign occupancy   = {1'b0, count_q} + {1'b0, drop_q};
  assign outstanding = drop_q + pend_q;

  always_comb begin
    req_valid = !rst && !PCsrcE && (occupancy < DepthOcc);
    valid_f   = !rst && !PCsrcE && filled_q[head_q] && (count_q != '0);
    req_fire  = req_valid && IReqReady;
    pop       = valid_f && ReadyD;
    resp_drop = IRespValid && (drop_q != '0);
    resp_fill = IRespValid && (drop_q == '0) && (pend_q != '0);
    head_pc   = pc_mem_q[head_q];
  end

  always_comb begin
    IReqValid = req_valid;
    IReqAddr  = pc_q;
    ValidF    = valid_f;
    PCF       = valid_f ? head_pc : '0;
    InstrF    = valid_f ? instr_mem_q[head_q] : '0;
    PCPlus4F  = valid_f ? head_pc + WIDTH'(4) : '0;
  end

  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_ptr_d  = fill_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (PCsrcE) begin
      pc_d       = {PCTargetE[WIDTH-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      // A response landing this cycle retires one of the outstanding requests.
      drop_d     = (IRespValid && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + WIDTH'(4);
        pc_mem_d[tail_q] = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + 1'b1;
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      if (resp_fill) begin
        instr_mem_d[fill_ptr_q] = IRespData;
        filled_d[fill_ptr_q]    = 1'b1;
        fill_ptr_d              = fill_ptr_q + 1'b1;
      end
      if (resp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      count_d = count_q + cnt_t'(req_fire) - cnt_t'(pop);
      pend_d  = pend_q + cnt_t'(req_fire) - cnt_t'(resp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ResetPc;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset; the filled flags and count qualify it.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a scoreboard of expected
// decode-side instructions, a cycle table for the reset/stream sequence and directed corners.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCsrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        IReqValid;
  logic [31:0] IReqAddr;
  logic        IReqReady = 1'b0;
  logic        IRespValid = 1'b0;
  logic [31:0] IRespData = '0;
  logic        ValidF;
  logic        ReadyD = 1'b0;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH   (32),
    .RESET_PC(32'h0),
    .DEPTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCsrcE    (PCsrcE),
    .PCTargetE (PCTargetE),
    .IReqValid (IReqValid),
    .IReqAddr  (IReqAddr),
    .IReqReady (IReqReady),
    .IRespValid(IRespValid),
    .IRespData (IRespData),
    .ValidF    (ValidF),
    .ReadyD    (ReadyD),
    .PCF       (PCF),
    .InstrF    (InstrF),
    .PCPlus4F  (PCPlus4F)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;

  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  bit          fire_req;
  bit          fire_resp;
  bit          cur_rst;
  bit          cur_pcs;
  logic [31:0] req_addr;

  typedef struct {
    bit          rst;
    bit          rr;
    bit          rd;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_vf;
    logic [31:0] exp_pcf;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and check decode-side outputs.
  task automatic apply(input bit r, input bit rr, input bit rd, input bit pcs,
                       input logic [31:0] tgt, input bit men);
    @(negedge clk);
    rst       = r;
    IReqReady = rr;
    ReadyD    = rd;
    PCsrcE    = pcs;
    PCTargetE = tgt;
    if (men && mem_q.size() > 0) begin
      IRespValid = 1'b1;
      IRespData  = instr_of(mem_q[0]);
    end else begin
      IRespValid = 1'b0;
      IRespData  = $urandom;
    end
    #1;
    fire_req  = IReqValid && IReqReady;
    req_addr  = IReqAddr;
    fire_resp = IRespValid;
    cur_rst   = r;
    cur_pcs   = pcs;
    if (fire_req) n_req++;
    if (ValidF) begin
      if (ReadyD) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got PCF %h, expected no instruction", PCF);
        end else begin
          check("pop_pc", PCF, exp_q[0]);
          check("pop_instr", InstrF, instr_of(exp_q[0]));
          check("pop_pc4", PCPlus4F, exp_q[0] + 32'd4);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("idle_pcf", PCF, 32'h0);
      check("idle_instr", InstrF, 32'h0);
      check("idle_pc4", PCPlus4F, 32'h0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (fire_resp) void'(mem_q.pop_front());
    if (fire_req) begin
      mem_q.push_back(req_addr);
      exp_q.push_back(req_addr);
    end
    if (cur_rst || cur_pcs) exp_q.delete();
  endtask

  task automatic step(input bit rr, input bit rd, input bit pcs, input logic [31:0] tgt,
                      input bit men);
    apply(1'b0, rr, rd, pcs, tgt, men);
    advance();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      advance();
    end
    mem_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_req(input string name, input bit v, input logic [31:0] addr);
    check({name, "_rv"}, {31'b0, IReqValid}, {31'b0, v});
    if (v) check({name, "_addr"}, IReqAddr, addr);
  endtask

  initial begin
    //        rst rr rd  rv addr        vf pcf
    tbl[0] = '{1, 1, 1, 0, 32'h0,  0, 32'h0};
    tbl[1] = '{0, 1, 1, 1, 32'h0,  0, 32'h0};
    tbl[2] = '{0, 1, 1, 1, 32'h4,  0, 32'h0};
    tbl[3] = '{0, 1, 1, 0, 32'h0,  1, 32'h0};
    tbl[4] = '{0, 1, 1, 1, 32'h8,  1, 32'h4};
    tbl[5] = '{0, 1, 1, 1, 32'hC,  0, 32'h0};
    tbl[6] = '{0, 1, 1, 0, 32'h0,  1, 32'h8};
    tbl[7] = '{0, 1, 1, 1, 32'h10, 1, 32'hC};

    // Reset and steady stream with single-cycle memory.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].rst, tbl[i].rr, tbl[i].rd, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("stream%0d", i), tbl[i].exp_rv, tbl[i].exp_addr);
      check($sformatf("stream%0d_vf", i), {31'b0, ValidF}, {31'b0, tbl[i].exp_vf});
      if (tbl[i].exp_vf) begin
        check($sformatf("stream%0d_pcf", i), PCF, tbl[i].exp_pcf);
        check($sformatf("stream%0d_pc4", i), PCPlus4F, tbl[i].exp_pcf + 32'd4);
      end
      advance();
    end

    // Decode stalled: only DEPTH requests may issue and the head holds.
    do_reset();
    n_req = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_rv", {31'b0, IReqValid}, 32'h0);
    check("bp_vf", {31'b0, ValidF}, 32'h1);
    check("bp_pcf", PCF, 32'h0);
    advance();
    check("bp_req_count", n_req, 32'd2);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with two requests outstanding: both responses must be dropped.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    expect_req("rd2_redir", 1'b0, 32'h0);
    check("rd2_redir_vf", {31'b0, ValidF}, 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("rd2_drop1", 1'b0, 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("rd2_drop2", 1'b1, 32'h100);
    advance();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rd2_vf", {31'b0, ValidF}, 32'h1);
    check("rd2_pcf", PCF, 32'h100);
    advance();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a response, unaligned target.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h103, 1'b1);
    expect_req("rdr_redir", 1'b0, 32'h0);
    check("rdr_redir_vf", {31'b0, ValidF}, 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_req("rdr_first", 1'b1, 32'h100);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("rdr_block", 1'b0, 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("rdr_second", 1'b1, 32'h104);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rdr_vf", {31'b0, ValidF}, 32'h1);
    check("rdr_pcf", PCF, 32'h100);
    advance();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Fetch PC wraps past the top of the address space.
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    expect_req("wrap_redir", 1'b0, 32'h0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("wrap_zero", 1'b1, 32'h0);
    advance();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Reset with a request in flight, then the late response arrives.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_req("rst_mid", 1'b0, 32'h0);
    check("rst_mid_vf", {31'b0, ValidF}, 32'h0);
    advance();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_req("rst_late", 1'b1, 32'h0);
    check("rst_late_vf", {31'b0, ValidF}, 32'h0);
    advance();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_after_vf", {31'b0, ValidF}, 32'h0);
    advance();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_new_vf", {31'b0, ValidF}, 32'h1);
    check("rst_new_pcf", PCF, 32'h0);
    advance();

    // Random traffic with variable memory latency and occasional redirects.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
